// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: operation codes and FSM states.
package mips_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_FIX  = 2'd3;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle on magnitudes, signs applied in FIX.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [SIZE-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] hi,
  output logic [SIZE-1:0] lo
);

  localparam int CW = $clog2(SIZE);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*SIZE-1:0]   acc_q, acc_d;
  logic [SIZE-1:0]     opnd_q, opnd_d;
  logic [SIZE-1:0]     a_orig_q, a_orig_d;
  logic [SIZE-1:0]     hi_q, hi_d;
  logic [SIZE-1:0]     lo_q, lo_d;
  logic                is_div_q, is_div_d;
  logic                sign_p_q, sign_p_d;
  logic                sign_r_q, sign_r_d;
  logic                dz_q, dz_d;
  logic                done_q, done_d;

  logic                is_signed;
  logic [SIZE-1:0]     mag_a, mag_b;
  logic [SIZE:0]       mul_sum;
  logic [SIZE:0]       div_shift;
  logic [SIZE+1:0]     div_diff;
  logic                div_ok;
  logic [2*SIZE-1:0]   prod_fix;
  logic [SIZE-1:0]     quo_fix, rem_fix;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a     = (is_signed && a[SIZE-1]) ? -a : a;
  assign mag_b     = (is_signed && b[SIZE-1]) ? -b : b;

  // Upper half holds the running product (mul) or partial remainder (div).
  assign mul_sum   = {1'b0, acc_q[2*SIZE-1:SIZE]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q[2*SIZE-1:SIZE], acc_q[SIZE-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_ok    = ~|div_diff[SIZE+1:SIZE];

  assign prod_fix  = sign_p_q ? -acc_q : acc_q;
  assign quo_fix   = sign_p_q ? -acc_q[SIZE-1:0] : acc_q[SIZE-1:0];
  assign rem_fix   = sign_r_q ? -acc_q[2*SIZE-1:SIZE] : acc_q[2*SIZE-1:SIZE];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_orig_d = a_orig_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    sign_p_d = sign_p_q;
    sign_r_d = sign_r_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d  = op[1] ? ST_DIV : ST_MUL;
          cnt_d    = CW'(SIZE - 1);
          opnd_d   = op[1] ? mag_b : mag_a;
          acc_d    = {{SIZE{1'b0}}, (op[1] ? mag_a : mag_b)};
          a_orig_d = a;
          is_div_d = op[1];
          sign_p_d = is_signed & (a[SIZE-1] ^ b[SIZE-1]);
          sign_r_d = is_signed & a[SIZE-1];
          dz_d     = op[1] && (b == '0);
        end
      end
      ST_MUL: begin
        acc_d = {mul_sum, acc_q[SIZE-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_DIV: begin
        acc_d = div_ok ? {div_diff[SIZE-1:0], acc_q[SIZE-2:0], 1'b1}
                       : {div_shift[SIZE-1:0], acc_q[SIZE-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      default: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          hi_d = a_orig_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_orig_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sign_p_q <= 1'b0;
      sign_r_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_orig_q <= a_orig_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      sign_p_q <= sign_p_d;
      sign_r_q <= sign_r_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, randomized ops against an
// arithmetic reference, HI/LO direct writes, busy-time rejection and mid-op reset.
module tb_mult_div_unit;

  localparam int SIZE = 32;
  localparam int LAT  = SIZE + 2;

  logic            clk;
  logic            reset;
  logic            start;
  logic [1:0]      op;
  logic [SIZE-1:0] a, b, wdata;
  logic            hi_we, lo_we;
  logic            busy, done;
  logic [SIZE-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic (SV division truncates toward zero).
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        q = sx * sy;
        p = q;
      end
      2'b01: p = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'd1;
      4: v = 32'($urandom_range(20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Launch one op, scramble inputs afterwards, check busy/done timing and the result.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input string name);
    int bad;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
    bad = 0;
    for (int k = 1; k <= SIZE + 1; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s busy_window: bad_cycles=%0d required=0", name, bad);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_cycle: done=%b busy=%b required done=1 busy=0", name, done, busy);
    end
    checks++;
    if (hi !== eh) begin
      failures++;
      $display("FAIL %s hi: got=%h required=%h", name, hi, eh);
    end
    checks++;
    if (lo !== el) begin
      failures++;
      $display("FAIL %s lo: got=%h required=%h", name, lo, el);
    end
  endtask

  // Bounded wait for done; reports the cycle index relative to the start edge.
  task automatic wait_done(input int first_cycle, output int at_cycle);
    int n;
    n = first_cycle;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    at_cycle = n;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    reset = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x, y, h, l;
  } vec_t;

  task automatic test_directed();
    vec_t v[7];
    v[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    v[2] = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A};
    v[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[4] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    v[5] = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    v[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    // Consecutive calls start in the previous op's done cycle (back-to-back).
    for (int i = 0; i < 7; i++)
      do_op(v[i].o, v[i].x, v[i].y, v[i].h, v[i].l, $sformatf("directed%0d", i));
    tick();
    checks++;
    if (done !== 1'b0 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
      failures++;
      $display("FAIL hold_after_done: done=%b hi=%h lo=%h required 0 0 80000000", done, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    logic [63:0] e;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(3));
      x = pick();
      y = pick();
      e = model(o, x, y);
      do_op(o, x, y, e[63:32], e[31:0], $sformatf("random%0d_op%0d_%h_%h", i, o, x, y));
    end
    tick();
  endtask

  task automatic test_mt();
    int at;
    hi_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h0000_1234) begin
      failures++;
      $display("FAIL mthi: hi=%h required=00001234", hi);
    end
    lo_we = 1'b1; wdata = 32'h0000_5678;
    tick();
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'h0000_5678 || hi !== 32'h0000_1234) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h required 00001234 00005678", hi, lo);
    end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD_0001;
    tick();
    checks++;
    if (hi !== 32'hABCD_0001 || lo !== 32'hABCD_0001) begin
      failures++;
      $display("FAIL mt_both: hi=%h lo=%h required abcd0001 abcd0001", hi, lo);
    end
    wdata = 32'hDEAD_BEEF; start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    tick();
    hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'hDEAD_BEEF || busy !== 1'b1) begin
      failures++;
      $display("FAIL mt_with_start: hi=%h lo=%h busy=%b required deadbeef deadbeef 1", hi, lo, busy);
    end
    wait_done(1, at);
    checks++;
    if (at != LAT || hi !== 32'd0 || lo !== 32'd6) begin
      failures++;
      $display("FAIL mt_overwrite: cycle=%0d hi=%h lo=%h required %0d 0 6", at, hi, lo, LAT);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    logic [31:0] x, y, old_hi;
    logic [63:0] e;
    int at;
    x = $urandom; y = $urandom;
    e = model(2'b00, x, y);
    old_hi = hi;
    start = 1'b1; op = 2'b00; a = x; b = y;
    tick();
    start = 1'b0;
    repeat (3) tick();
    hi_we = 1'b1; wdata = ~old_hi; start = 1'b1; op = 2'b11; a = $urandom; b = 32'd3;
    tick();
    hi_we = 1'b0; start = 1'b0;
    checks++;
    if (hi !== old_hi) begin
      failures++;
      $display("FAIL write_while_busy: hi=%h required=%h", hi, old_hi);
    end
    wait_done(5, at);
    checks++;
    if (at != LAT || hi !== e[63:32] || lo !== e[31:0]) begin
      failures++;
      $display("FAIL start_while_busy: cycle=%0d hi=%h lo=%h required %0d %h %h", at, hi, lo, LAT, e[63:32], e[31:0]);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL no_queued_op: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abandoned_op_done: active_cycles=%0d required=0", seen);
    end
    do_op(2'b01, 32'd3, 32'd4, 32'd0, 32'h0000_000C, "after_reset");
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mt();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and stalls the pipeline through `busy`.
- HI/LO outputs feed the writeback-select 2:1 muxes that implement MFHI/MFLO.
- MTHI/MTLO write HI/LO directly.

Parameters:
- SIZE, 32, operand and HI/LO width. Must be an even number ≥ 4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- a  in  SIZE  rs operand (multiplicand / dividend)
- b  in  SIZE  rt operand (multiplier / divisor)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  SIZE  MTHI/MTLO data
- busy  out  1  operation in flight; pipeline must stall MFHI/MFLO/MT*/new start
- done  out  1  one-cycle pulse: new HI/LO visible this cycle
- hi  out  SIZE  HI register
- lo  out  SIZE  LO register

Behaviour:
- Reset, synchronous, wins over everything:
  - state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - A reset mid-operation abandons the operation; no done pulse follows.
- States: IDLE → MUL or DIV → FIX → IDLE.
  - IDLE, start=1, op[1]=0 → MUL; op[1]=1 → DIV.
  - MUL/DIV run exactly SIZE iterations, one per cycle, counter SIZE-1 down to 0, then → FIX.
  - FIX: sign correction, HI/LO written at its end, then → IDLE.
- Timing, with start sampled at edge t:
  - busy=1 during cycles t+1 … t+SIZE+1 (SIZE+1 cycles).
  - done=1 and new hi/lo visible in cycle t+SIZE+2. busy=0 in that same cycle.
  - A back-to-back start in the done cycle is accepted.
- Operand capture: a, b and op are latched at start; later changes are ignored.
- Signed ops: operands are converted to magnitudes at capture. Result signs are recorded: product/quotient sign = a[SIZE-1]^b[SIZE-1]; remainder sign = a[SIZE-1].
- Multiply: shift-add on magnitudes, 2*SIZE-bit accumulator. FIX negates the 2*SIZE product if its sign is set. {hi,lo} = product.
- Divide: restoring, one quotient bit per cycle, SIZE+1-bit partial remainder. FIX negates the quotient and the remainder independently. lo = quotient (truncated toward zero), hi = remainder.
- Divide by zero (b=0, any op): lo = all ones, hi = a (original, unmodified). No exception; same latency.
- Signed overflow (DIV, a=100…0, b=all ones): lo = 100…0, hi = 0.
- MTHI/MTLO:
  - hi_we/lo_we write wdata at the clock edge, but only when busy=0.
  - Writes while busy are ignored.
  - hi_we and lo_we together: both registers are written.
  - hi_we/lo_we in the same cycle as an accepted start: the write takes effect, and the later result overwrites it.
- start while busy=1 is ignored (no queuing).
- hi/lo hold their values in every cycle not listed above; done=0 otherwise.

Decomposition:
- Shared package mips_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU (2-bit)
  - state enum {IDLE, MUL, DIV, FIX}
- Single module. No sub-module is natural: the multiply and divide datapaths share the accumulator, counter and FIX negation logic.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF, start at t → busy t+1..t+33, done only at t+34, hi=FFFFFFFE lo=00000001.
- MULT a=FFFFFFFD (-3) b=00000005 → hi=FFFFFFFF lo=FFFFFFF1. MULT a=7 b=6 → hi=0 lo=2A.
- DIV a=FFFFFFF9 (-7) b=2 → lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=64 b=7 → lo=E, hi=2.
- DIVU a=7 b=0 → lo=FFFFFFFF hi=7. DIV a=80000000 b=FFFFFFFF → lo=80000000 hi=0.
- MTHI wdata=1234 while idle → hi=1234 next cycle. Pulse start, then hi_we=1 and a second start at t+5 → both ignored; the first op's result lands at t+34.
- Start MULTU, assert reset at t+10 → t+11: busy=0, hi=lo=0, and done never asserts. Then MULTU a=3 b=4 → lo=C after 34 cycles.
